// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    D_ACC = 2'd1,
    I_ACC = 2'd2
  } arb_state_t;

  // Read data returned to the requester when an access is aborted by timeout.
  localparam logic [31:0] ARB_TIMEOUT_DATA = 32'hDEAD_BEEF;

  // Requester identifiers.
  localparam logic ARB_ID_I = 1'b0;
  localparam logic ARB_ID_D = 1'b1;

  // A requester may be granted only while it is not being acknowledged,
  // so a request the pipeline has not yet retired is never issued twice.
  function automatic logic isEligible(input logic req, input logic ack);
    return req & ~ack;
  endfunction

endpackage

// File: rtl/arb_timer.sv
// Clearable, enabled up-counter with terminal-count flag for access timeouts.
// A TIMEOUT of zero disables the terminal count entirely.
module arb_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  logic [CW-1:0] countR;

  // Count cycles spent in an access; cleared whenever the arbiter is idle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      countR <= {CW{1'b0}};
    end else if (clr) begin
      countR <= {CW{1'b0}};
    end else if (en) begin
      countR <= countR + CW'(1'b1);
    end else begin
      countR <= countR;
    end
  end

  // Terminal count once the configured number of wait cycles has elapsed.
  always_comb begin
    tc = 1'b0;
    if (TIMEOUT == 0) begin
      tc = 1'b0;
    end else begin
      tc = (countR == CW'(TIMEOUT));
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: data side has fixed priority over fetch, each
// grant is held until the memory acks or the timeout aborts the access.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic [DW-1:0]   i_rdata,
  output logic            i_ack,
  input  logic            d_req,
  input  logic [DW/8-1:0] d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ack,
  output logic            stall,
  output logic            err,
  output logic            m_req,
  output logic [DW/8-1:0] m_we,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata,
  input  logic            m_ack
);

  arb_state_t      stateR;
  logic            mReqR;
  logic [DW/8-1:0] mWeR;
  logic [AW-1:0]   mAddrR;
  logic [DW-1:0]   mWdataR;
  logic [DW-1:0]   iRdataR;
  logic [DW-1:0]   dRdataR;
  logic            iAckR;
  logic            dAckR;
  logic            errR;

  logic            tcS;
  logic            dEligS;
  logic            iEligS;
  logic            doneS;
  logic            ownerS;
  logic            loadDataS;
  logic [DW-1:0]   respDataS;

  arb_timer #(.TIMEOUT(TIMEOUT)) uTimer (
    .clk (clk),
    .rst (rst),
    .clr (stateR == IDLE),
    .en  (stateR != IDLE),
    .tc  (tcS)
  );

  // Eligibility and completion decode; m_ack takes precedence over timeout.
  always_comb begin
    dEligS    = isEligible(d_req, dAckR);
    iEligS    = isEligible(i_req, iAckR);
    doneS     = 1'b0;
    ownerS    = ARB_ID_I;
    respDataS = m_rdata;
    loadDataS = 1'b0;
    if (stateR == D_ACC || stateR == I_ACC) begin
      doneS  = m_ack | tcS;
      ownerS = (stateR == D_ACC) ? ARB_ID_D : ARB_ID_I;
    end else begin
      doneS  = 1'b0;
      ownerS = ARB_ID_I;
    end
    if (m_ack) begin
      respDataS = m_rdata;
      loadDataS = ~|mWeR;
    end else begin
      respDataS = DW'(ARB_TIMEOUT_DATA);
      loadDataS = 1'b1;
    end
  end

  // Arbitration FSM with registered memory request and response outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      stateR  <= IDLE;
      mReqR   <= 1'b0;
      mWeR    <= {(DW/8){1'b0}};
      mAddrR  <= {AW{1'b0}};
      mWdataR <= {DW{1'b0}};
      iRdataR <= {DW{1'b0}};
      dRdataR <= {DW{1'b0}};
      iAckR   <= 1'b0;
      dAckR   <= 1'b0;
      errR    <= 1'b0;
    end else begin
      iAckR <= 1'b0;
      dAckR <= 1'b0;
      errR  <= 1'b0;
      case (stateR)
        IDLE: begin
          if (dEligS) begin
            stateR  <= D_ACC;
            mReqR   <= 1'b1;
            mWeR    <= d_we;
            mAddrR  <= d_addr;
            mWdataR <= d_wdata;
          end else if (iEligS) begin
            stateR  <= I_ACC;
            mReqR   <= 1'b1;
            mWeR    <= {(DW/8){1'b0}};
            mAddrR  <= i_addr;
            mWdataR <= {DW{1'b0}};
          end else begin
            stateR <= IDLE;
          end
        end
        D_ACC, I_ACC: begin
          if (doneS) begin
            stateR <= IDLE;
            mReqR  <= 1'b0;
            errR   <= ~m_ack;
            if (ownerS == ARB_ID_D) begin
              dAckR <= 1'b1;
              if (loadDataS) begin
                dRdataR <= respDataS;
              end else begin
                dRdataR <= dRdataR;
              end
            end else begin
              iAckR   <= 1'b1;
              iRdataR <= respDataS;
            end
          end else begin
            stateR <= stateR;
          end
        end
        default: begin
          stateR <= IDLE;
          mReqR  <= 1'b0;
        end
      endcase
    end
  end

  assign m_req   = mReqR;
  assign m_we    = mWeR;
  assign m_addr  = mAddrR;
  assign m_wdata = mWdataR;
  assign i_rdata = iRdataR;
  assign d_rdata = dRdataR;
  assign i_ack   = iAckR;
  assign d_ack   = dAckR;
  assign err     = errR;

  // Pipeline freeze while either side has an access that is not completing.
  assign stall = (i_req & ~iAckR) | (d_req & ~dAckR);

endmodule
